// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and the types passed between the arbiter and its
// write FIFO.
package fb_pkg;

  localparam int H_SIZE    = 320;
  localparam int V_SIZE    = 240;
  localparam int FB_WORDS  = H_SIZE * V_SIZE;
  localparam int FB_ADDR_W = $clog2(FB_WORDS);

  typedef logic [15:0] pixel_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    pixel_t               data;
  } fb_wr_t;

  typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} gnt_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of pending camera writes.
// Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fb_wr_t       din,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count,
  output fb_wr_t       head
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  fb_wr_t           entry_reg [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = entry_reg[rd_ptr_reg];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) entry_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one frame-buffer RAM port: display reads always win, camera writes are
// queued and drained into cycles with no read request.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 17,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [15:0]       cam_wdata,
  output logic              cam_full,
  input  logic              flush,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              ovf,
  input  logic              ovf_clr
);

  gnt_t       gnt;
  fb_wr_t     fifo_din;
  fb_wr_t     fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       ovf_set;
  logic       ovf_reg;
  logic       rd_valid_reg;

  assign fifo_din.addr = FB_ADDR_W'(cam_addr);
  assign fifo_din.data = cam_wdata;
  assign fifo_pop      = (gnt == GNT_WRITE);

  fb_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cam_we),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_level),
    .head  (fifo_head)
  );

  // A flushing cycle may never retire a write: the head is being discarded.
  always_comb begin
    gnt = GNT_IDLE;
    if (!reset) begin
      if (rd_req)                    gnt = GNT_READ;
      else if (!fifo_empty && !flush) gnt = GNT_WRITE;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      GNT_READ: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      GNT_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(fifo_head.addr);
        mem_wdata = fifo_head.data;
      end
      default: ;
    endcase
  end

  assign ovf_set = cam_we && fifo_full && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_req;
      if (ovf_set)      ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign ovf      = ovf_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = mem_rdata;
  assign cam_full = fifo_full;

endmodule
